// File: rtl/mag_comp_pkg.sv
// mag_comp_pkg: shared constants and helpers for the pipelined magnitude comparator.
// Holds the default operand/slice widths, the stage-count function and the 2-bit
// result encoding that downstream sorters use to rank comparator outputs.
package mag_comp_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int SLICE_DEF = 4;

    // Compact result code consumed by sorters: exactly one of GT/LT/EQ per pair.
    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_LT = 2'b01,
        CMP_GT = 2'b10
    } cmp_res_e;

    // Number of pipeline stages needed to consume a width-bit operand slice by slice.
    function automatic int stages_f(input int width, input int slice);
        return width / slice;
    endfunction

    // Folds the comparator flags into the result code.
    function automatic cmp_res_e cmp_encode(input logic gt, input logic lt);
        cmp_res_e r;
        if (gt)
            r = CMP_GT;
        else if (lt)
            r = CMP_LT;
        else
            r = CMP_EQ;
        return r;
    endfunction

endpackage

// File: rtl/mag_comp_slice.sv
// mag_comp_slice: purely combinational unsigned compare of one SLICE-bit chunk.
// One instance per pipeline stage; sign handling is done by the caller.
module mag_comp_slice
    import mag_comp_pkg::*;
#(
    parameter int SLICE = SLICE_DEF
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    output logic             gt_o,
    output logic             lt_o
);

    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);

endmodule

// File: rtl/mag_comp_pipe.sv
// mag_comp_pipe: pipelined WIDTH-bit magnitude comparator with valid/ready flow control.
// Operands are compared MSB slice first, SLICE bits per stage; the first stage that
// sees a difference latches gt/lt and later stages just forward the decision.
// Optional feature: define MAG_COMP_MINMAX_EN to carry full operands and present
// registered max_o/min_o alongside each result.
module mag_comp_pipe
    import mag_comp_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             xgty,
    output logic             xlty,
`ifdef MAG_COMP_MINMAX_EN
    output logic [WIDTH-1:0] max_o,
    output logic [WIDTH-1:0] min_o,
`endif
    output logic             xeqy
);

    localparam int STAGES = stages_f(WIDTH, SLICE);
    localparam int L      = STAGES - 1;
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [SLICE-1:0] MSB_MASK = SLICE'(1) << (SLICE - 1);

    if (((WIDTH % SLICE) != 0) || (STAGES < 1)) begin : g_bad_cfg
        $error("mag_comp_pipe: WIDTH (%0d) must be a non-zero multiple of SLICE (%0d)", WIDTH, SLICE);
    end

    logic [STAGES-1:0] vld_all;
    logic [STAGES-1:0] rdy;

    // Stage k can load when any stage from k to the output is empty, or the consumer takes a result.
    always_comb begin
        logic full_tail;
        rdy       = '0;
        full_tail = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full_tail = full_tail & vld_all[k];
            rdy[k]    = out_ready | ~full_tail;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int HI = WIDTH - 1 - k * SLICE;
`ifdef MAG_COMP_MINMAX_EN
        // Full operands ride along; the last stage turns them into max/min instead.
        localparam int PW = WIDTH;
        localparam int RW = (k == STAGES - 1) ? 0 : WIDTH;
`else
        // Only bits not yet compared are kept, so each stage is SLICE bits narrower.
        localparam int PW = WIDTH - k * SLICE;
        localparam int RW = WIDTH - (k + 1) * SLICE;
`endif
        logic [PW-1:0]    xs, ys;
        logic             vs, gs, ls, ss;
        logic [SLICE-1:0] sx, sy;
        logic             cmp_gt, cmp_lt;
        logic             gt_d, lt_d;
        logic             vld_q, gt_q, lt_q, sgn_q;

        if (k == 0) begin : g_src
            assign xs = x;
            assign ys = y;
            assign vs = in_valid;
            assign gs = 1'b0;
            assign ls = 1'b0;
            assign ss = is_signed;
            assign sx = xs[HI -: SLICE] ^ (is_signed ? MSB_MASK : '0);
            assign sy = ys[HI -: SLICE] ^ (is_signed ? MSB_MASK : '0);
        end else begin : g_src
            assign xs = g_st[k-1].g_res.x_q;
            assign ys = g_st[k-1].g_res.y_q;
            assign vs = g_st[k-1].vld_q;
            assign gs = g_st[k-1].gt_q;
            assign ls = g_st[k-1].lt_q;
            assign ss = g_st[k-1].sgn_q;
            assign sx = xs[HI -: SLICE];
            assign sy = ys[HI -: SLICE];
        end

        mag_comp_slice #(
            .SLICE (SLICE)
        ) u_slice (
            .a_i  (sx),
            .b_i  (sy),
            .gt_o (cmp_gt),
            .lt_o (cmp_lt)
        );

        // An earlier decision wins; only an undecided pair looks at this slice.
        assign gt_d = (gs | ls) ? gs : cmp_gt;
        assign lt_d = (gs | ls) ? ls : cmp_lt;

        assign vld_all[k] = vld_q;

        // Stage control and decision flags advance whenever this stage is ready.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                gt_q  <= 1'b0;
                lt_q  <= 1'b0;
                sgn_q <= 1'b0;
            end else if (rdy[k]) begin
                vld_q <= vs;
                gt_q  <= gt_d;
                lt_q  <= lt_d;
                sgn_q <= ss;
            end
        end

        if (RW > 0) begin : g_res
            logic [RW-1:0] x_q, y_q;

            // Operand bits still needed downstream move with the stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    x_q <= '0;
                    y_q <= '0;
                end else if (rdy[k]) begin
                    x_q <= xs[RW-1:0];
                    y_q <= ys[RW-1:0];
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = g_st[L].vld_q;
    assign xgty      = out_valid & g_st[L].gt_q;
    assign xlty      = out_valid & g_st[L].lt_q;
    assign xeqy      = out_valid & ~g_st[L].gt_q & ~g_st[L].lt_q;

    // The signed flag has done its job once the final stage is reached.
    logic unused_sgn;
    assign unused_sgn = g_st[L].sgn_q;

`ifdef MAG_COMP_MINMAX_EN
    logic [WIDTH-1:0] max_d, min_d;
    logic [WIDTH-1:0] max_q, min_q;

    // Equal operands take the "not greater" branch, so both outputs equal x.
    assign max_d = g_st[L].gt_d ? g_st[L].xs : g_st[L].ys;
    assign min_d = g_st[L].gt_d ? g_st[L].ys : g_st[L].xs;

    // max/min are captured together with the final stage so they track out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
            min_q <= '0;
        end else if (rdy[L]) begin
            max_q <= max_d;
            min_q <= min_d;
        end
    end

    assign max_o = max_q;
    assign min_o = min_q;
`endif

endmodule
